// File: rtl/conv_sched_if.sv
`default_nettype none
// =============================================================================
// Module   : conv_sched_if
// Brief    : Control, RAM-read and result handshake bundle of conv_sched.
// Revision : 1.0 - initial release
// =============================================================================
interface conv_sched_if #(
    parameter int BITWIDTH = 8,
    parameter int ACCW     = 24,
    parameter int DATA_AW  = 12,
    parameter int WT_AW    = 6,
    parameter int IDX_W    = 11
);
    logic                start;
    logic                busy;
    logic                done;
    logic                data_rd_en;
    logic [DATA_AW-1:0]  data_addr;
    logic [BITWIDTH-1:0] data_rdata;
    logic                wt_rd_en;
    logic [WT_AW-1:0]    wt_addr;
    logic [BITWIDTH-1:0] wt_rdata;
    logic                result_valid;
    logic                result_ready;
    logic [ACCW-1:0]     result_data;
    logic [IDX_W-1:0]    result_idx;

    modport master (
        input  start,
        output busy, done,
        output data_rd_en, data_addr,
        input  data_rdata,
        output wt_rd_en, wt_addr,
        input  wt_rdata,
        output result_valid,
        input  result_ready,
        output result_data, result_idx
    );

    modport slave (
        output start,
        input  busy, done,
        input  data_rd_en, data_addr,
        output data_rdata,
        input  wt_rd_en, wt_addr,
        output wt_rdata,
        input  result_valid,
        output result_ready,
        input  result_data, result_idx
    );
endinterface
`default_nettype wire

// File: rtl/conv_sched.sv
`default_nettype none
// =============================================================================
// Module   : conv_sched
// Brief    : Single time-shared MAC walking every output of a multi-channel,
//            multi-filter valid convolution held in external RAMs.
// Revision : 1.0 - initial release
// =============================================================================
module conv_sched #(
    parameter int BITWIDTH     = 8,
    parameter int FILTERWIDTH  = 3,
    parameter int FILTERHEIGHT = 3,
    parameter int STRIDE       = 1,
    parameter int CHANNEL      = 3,
    parameter int DATAWIDTH    = 28,
    parameter int DATAHEIGHT   = 28,
    parameter int BATCH        = 2,
    parameter int ACCW         = 2*BITWIDTH+8
) (
    input wire           clk,
    input wire           rst_n,
    conv_sched_if.master bus
);
    localparam int c_OW      = (DATAWIDTH - FILTERWIDTH) / STRIDE + 1;
    localparam int c_OH      = (DATAHEIGHT - FILTERHEIGHT) / STRIDE + 1;
    localparam int c_TAPS    = FILTERHEIGHT * FILTERWIDTH;
    localparam int c_K       = CHANNEL * c_TAPS;
    localparam int c_PLANE   = DATAHEIGHT * DATAWIDTH;
    localparam int c_NOUT    = BATCH * c_OH * c_OW;
    localparam int c_DATA_AW = (CHANNEL * c_PLANE > 1) ? $clog2(CHANNEL * c_PLANE) : 1;
    localparam int c_WT_AW   = (BATCH * c_K > 1) ? $clog2(BATCH * c_K) : 1;
    localparam int c_IDX_W   = (c_NOUT > 1) ? $clog2(c_NOUT) : 1;
    localparam int c_B_W     = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam int c_R_W     = (c_OH > 1) ? $clog2(c_OH) : 1;
    localparam int c_X_W     = (c_OW > 1) ? $clog2(c_OW) : 1;
    localparam int c_C_W     = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam int c_M_W     = (FILTERHEIGHT > 1) ? $clog2(FILTERHEIGHT) : 1;
    localparam int c_N_W     = (FILTERWIDTH > 1) ? $clog2(FILTERWIDTH) : 1;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RUN  = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_OUT  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_B_W-1:0]   r_b, w_b_nxt;
    logic [c_R_W-1:0]   r_r, w_r_nxt;
    logic [c_X_W-1:0]   r_x, w_x_nxt;
    logic [c_C_W-1:0]   r_c, w_c_nxt;
    logic [c_M_W-1:0]   r_m, w_m_nxt;
    logic [c_N_W-1:0]   r_n, w_n_nxt;
    logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
    logic               w_load;
    logic               w_last_tap;
    logic               w_last_out;
    logic [c_DATA_AW-1:0] r_data_addr, w_data_addr_nxt;
    logic [c_WT_AW-1:0]   r_wt_addr, w_wt_addr_nxt;
    logic               r_acc_en;
    logic               r_acc_first;
    logic [ACCW-1:0]    r_acc;
    logic [ACCW-1:0]    w_d_ext, w_w_ext, w_prod;

    assign w_last_tap = (r_c == c_C_W'(CHANNEL - 1)) &&
                        (r_m == c_M_W'(FILTERHEIGHT - 1)) &&
                        (r_n == c_N_W'(FILTERWIDTH - 1));
    assign w_last_out = (r_idx == c_IDX_W'(c_NOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_r_nxt     = r_r;
        w_x_nxt     = r_x;
        w_c_nxt     = r_c;
        w_m_nxt     = r_m;
        w_n_nxt     = r_n;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_RUN;
                    w_b_nxt     = '0;
                    w_r_nxt     = '0;
                    w_x_nxt     = '0;
                    w_c_nxt     = '0;
                    w_m_nxt     = '0;
                    w_n_nxt     = '0;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            c_RUN: begin
                if (w_last_tap) begin
                    w_state_nxt = c_WAIT;
                end else begin
                    w_load = 1'b1;
                    if (r_n != c_N_W'(FILTERWIDTH - 1)) begin
                        w_n_nxt = r_n + c_N_W'(1);
                    end else begin
                        w_n_nxt = '0;
                        if (r_m != c_M_W'(FILTERHEIGHT - 1)) begin
                            w_m_nxt = r_m + c_M_W'(1);
                        end else begin
                            w_m_nxt = '0;
                            w_c_nxt = r_c + c_C_W'(1);
                        end
                    end
                end
            end
            c_WAIT: w_state_nxt = c_OUT;
            c_OUT: begin
                if (bus.result_ready) begin
                    if (w_last_out) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_RUN;
                        w_load      = 1'b1;
                        w_c_nxt     = '0;
                        w_m_nxt     = '0;
                        w_n_nxt     = '0;
                        w_idx_nxt   = r_idx + c_IDX_W'(1);
                        if (r_x != c_X_W'(c_OW - 1)) begin
                            w_x_nxt = r_x + c_X_W'(1);
                        end else begin
                            w_x_nxt = '0;
                            if (r_r != c_R_W'(c_OH - 1)) begin
                                w_r_nxt = r_r + c_R_W'(1);
                            end else begin
                                w_r_nxt = '0;
                                w_b_nxt = r_b + c_B_W'(1);
                            end
                        end
                    end
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Addresses are formed from the tap about to be issued so they register alongside rd_en.
    assign w_data_addr_nxt = c_DATA_AW'(32'(w_c_nxt) * c_PLANE +
                             (32'(w_r_nxt) * STRIDE + 32'(w_m_nxt)) * DATAWIDTH +
                             32'(w_x_nxt) * STRIDE + 32'(w_n_nxt));
    assign w_wt_addr_nxt   = c_WT_AW'(32'(w_b_nxt) * c_K + 32'(w_c_nxt) * c_TAPS +
                             32'(w_m_nxt) * FILTERWIDTH + 32'(w_n_nxt));

    // Operands widened to ACCW; the low ACCW bits of the product are the signed result.
    assign w_d_ext = {{(ACCW-BITWIDTH){bus.data_rdata[BITWIDTH-1]}}, bus.data_rdata};
    assign w_w_ext = {{(ACCW-BITWIDTH){bus.wt_rdata[BITWIDTH-1]}}, bus.wt_rdata};
    assign w_prod  = w_d_ext * w_w_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_b         <= '0;
            r_r         <= '0;
            r_x         <= '0;
            r_c         <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_idx       <= '0;
            r_data_addr <= '0;
            r_wt_addr   <= '0;
            r_acc_en    <= 1'b0;
            r_acc_first <= 1'b0;
            r_acc       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_b         <= w_b_nxt;
            r_r         <= w_r_nxt;
            r_x         <= w_x_nxt;
            r_c         <= w_c_nxt;
            r_m         <= w_m_nxt;
            r_n         <= w_n_nxt;
            r_idx       <= w_idx_nxt;
            if (w_load) begin
                r_data_addr <= w_data_addr_nxt;
                r_wt_addr   <= w_wt_addr_nxt;
            end
            r_acc_en    <= (r_state == c_RUN);
            r_acc_first <= (r_state == c_RUN) && (r_c == '0) && (r_m == '0) && (r_n == '0);
            if (r_acc_en) begin
                r_acc <= (r_acc_first ? '0 : r_acc) + w_prod;
            end
        end
    end

    assign bus.busy         = (r_state != c_IDLE);
    assign bus.done         = (r_state == c_DONE);
    assign bus.data_rd_en   = (r_state == c_RUN);
    assign bus.wt_rd_en     = (r_state == c_RUN);
    assign bus.data_addr    = r_data_addr;
    assign bus.wt_addr      = r_wt_addr;
    assign bus.result_valid = (r_state == c_OUT);
    assign bus.result_data  = r_acc;
    assign bus.result_idx   = r_idx;
endmodule
`default_nettype wire
